// File: rtl/ens_vote_argmax.sv
// Ensemble vote counter: latches one vector of per-member class bits, tallies votes one class per cycle,
// and hands the lowest-index winning class and its vote count over valid/ready. Optional tie flag: ENS_VOTE_TIE_FLAG_EN.
module ens_vote_argmax #(
    parameter int N_ENS   = 4,
    parameter int N_CLASS = 10,
    parameter int CLASS_W = 4,
    parameter int VOTE_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_ENS*N_CLASS-1:0]   in_bits,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CLASS_W-1:0]         out_class,
    output logic [VOTE_W-1:0]          out_votes
`ifdef ENS_VOTE_TIE_FLAG_EN
    ,
    output logic                       out_tie
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [VOTE_W-1:0] popcount(input logic [N_ENS-1:0] b);
        logic [VOTE_W-1:0] acc;
        acc = {VOTE_W{1'b0}};
        for (int i = 0; i < N_ENS; i++) begin
            acc = acc + VOTE_W'(b[i]);
        end
        return acc;
    endfunction

    state_t                     state_r;
    state_t                     state_n_s;
    logic [N_ENS*N_CLASS-1:0]   vec_r;
    logic [CLASS_W-1:0]         cnt_r;
    logic [CLASS_W-1:0]         best_class_r;
    logic [VOTE_W-1:0]          best_votes_r;
    logic [N_ENS-1:0]           col_s [N_CLASS];
    logic [N_ENS-1:0]           class_bits_s;
    logic [VOTE_W-1:0]          v_s;
    logic                       last_s;
    logic                       take_s;
    logic [CLASS_W-1:0]         best_class_n_s;
    logic [VOTE_W-1:0]          best_votes_n_s;
`ifdef ENS_VOTE_TIE_FLAG_EN
    logic                       tie_r;
    logic                       tie_n_s;
`endif

    // Regroup the latched vector by class so the current class column is a single array select.
    always_comb begin
        for (int c = 0; c < N_CLASS; c++) begin
            for (int m = 0; m < N_ENS; m++) begin
                col_s[c][m] = vec_r[m*N_CLASS + c];
            end
        end
        class_bits_s = col_s[cnt_r];
        v_s          = popcount(class_bits_s);
        last_s       = (cnt_r == CLASS_W'(N_CLASS - 1));
    end

    // Running argmax: class 0 seeds the best, later classes must strictly beat it so ties keep the lower index.
    always_comb begin
        take_s = (cnt_r == {CLASS_W{1'b0}}) || (v_s > best_votes_r);
        if (take_s) begin
            best_class_n_s = cnt_r;
            best_votes_n_s = v_s;
        end else begin
            best_class_n_s = best_class_r;
            best_votes_n_s = best_votes_r;
        end
`ifdef ENS_VOTE_TIE_FLAG_EN
        if (take_s) begin
            tie_n_s = 1'b0;
        end else if ((v_s == best_votes_r) && (v_s != {VOTE_W{1'b0}})) begin
            tie_n_s = 1'b1;
        end else begin
            tie_n_s = tie_r;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_n_s = COUNT;
                else          state_n_s = IDLE;
            end
            COUNT: begin
                if (last_s) state_n_s = DONE;
                else        state_n_s = COUNT;
            end
            DONE: begin
                if (out_ready) state_n_s = IDLE;
                else           state_n_s = DONE;
            end
            default: state_n_s = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            in_ready  <= (state_n_s == IDLE);
            out_valid <= (state_n_s == DONE);
        end
    end

    // Datapath: latch on accept, accumulate during COUNT, publish the result on the last class.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_r        <= {(N_ENS*N_CLASS){1'b0}};
            cnt_r        <= {CLASS_W{1'b0}};
            best_class_r <= {CLASS_W{1'b0}};
            best_votes_r <= {VOTE_W{1'b0}};
            out_class    <= {CLASS_W{1'b0}};
            out_votes    <= {VOTE_W{1'b0}};
`ifdef ENS_VOTE_TIE_FLAG_EN
            tie_r        <= 1'b0;
            out_tie      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        vec_r        <= in_bits;
                        cnt_r        <= {CLASS_W{1'b0}};
                        best_class_r <= {CLASS_W{1'b0}};
                        best_votes_r <= {VOTE_W{1'b0}};
`ifdef ENS_VOTE_TIE_FLAG_EN
                        tie_r        <= 1'b0;
`endif
                    end
                end
                COUNT: begin
                    cnt_r        <= cnt_r + CLASS_W'(1);
                    best_class_r <= best_class_n_s;
                    best_votes_r <= best_votes_n_s;
`ifdef ENS_VOTE_TIE_FLAG_EN
                    tie_r        <= tie_n_s;
`endif
                    if (last_s) begin
                        out_class <= best_class_n_s;
                        out_votes <= best_votes_n_s;
`ifdef ENS_VOTE_TIE_FLAG_EN
                        out_tie   <= tie_n_s;
`endif
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CLASS_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Self-checking bench for ens_vote_argmax: directed table, random vectors against a vote-count model,
// and hand-written backpressure / mid-count reset / throughput sequences.
module tb_ens_vote_argmax;
    localparam int N_ENS   = 4;
    localparam int N_CLASS = 10;
    localparam int CLASS_W = 4;
    localparam int VOTE_W  = 3;
    localparam int NB      = N_ENS * N_CLASS;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [NB-1:0]      in_bits;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] out_class;
    logic [VOTE_W-1:0]  out_votes;
`ifdef ENS_VOTE_TIE_FLAG_EN
    logic               out_tie;
`endif

    int n_vec = 0;
    int n_err = 0;

    ens_vote_argmax #(.N_ENS(N_ENS), .N_CLASS(N_CLASS), .CLASS_W(CLASS_W), .VOTE_W(VOTE_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_votes(out_votes)
`ifdef ENS_VOTE_TIE_FLAG_EN
        , .out_tie(out_tie)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] bits;
        int            cls;
        int            votes;
        int            tie;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] vote(input int m, input int c);
        logic [NB-1:0] one;
        one = {{(NB-1){1'b0}}, 1'b1};
        return one << (m*N_CLASS + c);
    endfunction

    // Reference: tally each class, pick the highest count with lowest index, flag another class at the same nonzero count.
    task automatic model(input logic [NB-1:0] bits, output int cls, output int votes, output int tie);
        int cnt [N_CLASS];
        for (int c = 0; c < N_CLASS; c++) begin
            cnt[c] = 0;
            for (int m = 0; m < N_ENS; m++) cnt[c] += int'(bits[m*N_CLASS + c]);
        end
        cls = 0;
        for (int c = 1; c < N_CLASS; c++) if (cnt[c] > cnt[cls]) cls = c;
        votes = cnt[cls];
        tie = 0;
        for (int c = 0; c < N_CLASS; c++) if (c != cls && cnt[c] == votes && votes > 0) tie = 1;
    endtask

    // Present a vector, wait for accept, then wait for the result and compare; leaves the bench in DONE.
    task automatic run_vec(input string tag, input logic [NB-1:0] bits, input int cls,
                           input int votes, input int tie, input bit chk_lat);
        int g;
        int lat;
        g = 0;
        in_bits  = bits;
        in_valid = 1'b1;
        while (!in_ready && g < 100) begin tick(); g++; end
        check({tag, " accept_timeout"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_bits  = NB'({$urandom, $urandom});
        lat = 1;
        while (!out_valid && lat < 60) begin tick(); lat++; end
        check({tag, " out_valid"}, int'(out_valid), 1);
        if (chk_lat) check({tag, " latency"}, lat, N_CLASS + 1);
        check({tag, " class"}, int'(out_class), cls);
        check({tag, " votes"}, int'(out_votes), votes);
`ifdef ENS_VOTE_TIE_FLAG_EN
        check({tag, " tie"}, int'(out_tie), tie);
`else
        if (tie < 0) $display("negative tie expectation for %s", tag);
`endif
        check({tag, " in_ready_done"}, int'(in_ready), 0);
    endtask

    initial begin
        vec_t tbl [6];
        logic [NB-1:0] b;
        int ec, ev, et;
        int acc_cyc [$];
        int cyc;
        logic [CLASS_W-1:0] hold_c;
        logic [VOTE_W-1:0]  hold_v;

        tbl[0] = '{vote(0,3) | vote(1,3) | vote(2,3) | vote(3,3), 3, 4, 0};
        tbl[1] = '{vote(0,7) | vote(1,7) | vote(2,2) | vote(3,9), 7, 2, 0};
        tbl[2] = '{vote(0,5) | vote(1,5) | vote(2,1) | vote(3,1), 1, 2, 1};
        tbl[3] = '{{NB{1'b0}}, 0, 0, 0};
        tbl[4] = '{{NB{1'b1}}, 0, 4, 1};
        tbl[5] = '{vote(0,9), 9, 1, 0};

        rst = 1'b1; in_valid = 1'b0; in_bits = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst in_ready", int'(in_ready), 1);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_class", int'(out_class), 0);
        check("rst out_votes", int'(out_votes), 0);
`ifdef ENS_VOTE_TIE_FLAG_EN
        check("rst out_tie", int'(out_tie), 0);
`endif

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].bits, tbl[i].cls, tbl[i].votes, tbl[i].tie, 1'b1);
            tick();
            check($sformatf("tbl%0d back_idle", i), int'(in_ready), 1);
        end

        for (int i = 0; i < 30; i++) begin
            b = NB'({$urandom, $urandom});
            if (i % 2 == 0) b = b & NB'({$urandom, $urandom});
            model(b, ec, ev, et);
            run_vec($sformatf("rnd%0d", i), b, ec, ev, et, 1'b0);
            tick();
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        model(tbl[1].bits, ec, ev, et);
        run_vec("bp", tbl[1].bits, ec, ev, et, 1'b1);
        hold_c = out_class; hold_v = out_votes;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== hold_c || out_votes !== hold_v)
                check($sformatf("bp hold%0d", i), 0, 1);
        end
        check("bp class_held", int'(out_class), 7);
        check("bp votes_held", int'(out_votes), 2);
        out_ready = 1'b1;
        tick();
        check("bp release in_ready", int'(in_ready), 1);
        check("bp release out_valid", int'(out_valid), 0);

        // Reset five cycles into counting, then a clean vector.
        in_bits = tbl[4].bits; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst in_ready", int'(in_ready), 1);
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst out_class", int'(out_class), 0);
        for (int i = 0; i < 15; i++) begin
            if (out_valid) check("midrst spurious_valid", 0, 1);
            tick();
        end
        run_vec("post_rst", tbl[5].bits, 9, 1, 0, 1'b1);
        tick();

        // Back-to-back with in_valid and out_ready held high: accepts every N_CLASS+2 cycles.
        in_valid = 1'b1; in_bits = '0;
        cyc = 0;
        while (acc_cyc.size() < 4 && cyc < 200) begin
            if (in_ready) acc_cyc.push_back(cyc);
            if (out_valid) begin
                check("b2b class", int'(out_class), 0);
                check("b2b votes", int'(out_votes), 0);
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b accepts", acc_cyc.size(), 4);
        for (int i = 1; i < acc_cyc.size(); i++)
            check($sformatf("b2b period%0d", i), acc_cyc[i] - acc_cyc[i-1], N_CLASS + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
